// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state
// encoding, register-address width and the default counter width.
package pipe_ctrl_pkg;

    localparam int REG_ADDR_W    = 5;
    localparam int CNT_W_DEFAULT = 16;
    localparam int FLUSH_CNT_W   = 3;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_FLUSH      = 2'd2,
        ST_MEM_WAIT   = 2'd3
    } state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle of pipeline-status inputs and stage-control outputs exchanged
// between the datapath (master) and the hazard controller (slave).
interface hazard_ctrl_if
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) ();

    logic                  id_ex_MemRead_i;
    logic [REG_ADDR_W-1:0] id_ex_wr_i;
    logic [REG_ADDR_W-1:0] if_id_rs1_i;
    logic [REG_ADDR_W-1:0] if_id_rs2_i;
    logic                  if_id_uses_rs2_i;
    logic                  branch_taken_i;
    logic                  dmem_busy_i;

    logic                  pc_write_o;
    logic                  if_id_write_o;
    logic                  id_ex_write_o;
    logic                  ex_mem_write_o;
    logic                  if_id_flush_o;
    logic                  id_ex_bubble_o;
    logic [1:0]            state_o;
    logic [CNT_W-1:0]      stall_cnt_o;
    logic [CNT_W-1:0]      flush_cnt_o;

    modport master (
        output id_ex_MemRead_i, id_ex_wr_i, if_id_rs1_i, if_id_rs2_i,
               if_id_uses_rs2_i, branch_taken_i, dmem_busy_i,
        input  pc_write_o, if_id_write_o, id_ex_write_o, ex_mem_write_o,
               if_id_flush_o, id_ex_bubble_o, state_o, stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  id_ex_MemRead_i, id_ex_wr_i, if_id_rs1_i, if_id_rs2_i,
               if_id_uses_rs2_i, branch_taken_i, dmem_busy_i,
        output pc_write_o, if_id_write_o, id_ex_write_o, ex_mem_write_o,
               if_id_flush_o, id_ex_bubble_o, state_o, stall_cnt_o, flush_cnt_o
    );

endinterface

// File: rtl/hazard_detect.sv
// Load-use detector: a load in EX whose destination is read by the
// instruction in ID. Writes to x0 never create a dependency.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic                  mem_read,
    input  logic [REG_ADDR_W-1:0] wr,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    input  logic                  uses_rs2,
    output logic                  load_use
);

    assign load_use = mem_read && (wr != '0) &&
                      ((wr == rs1) || (uses_rs2 && (wr == rs2)));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller. Stage enables, flush and bubble are Mealy
// outputs resolved in the same cycle with priority
// memory-busy > taken branch > load-use. Two saturating counters record
// stalled cycles and taken branches.
module hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = CNT_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    hazard_ctrl_if.slave bus
);

    localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD  = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
    localparam bit                     MULTI_FLUSH = (FLUSH_CYCLES > 1);

    state_t                 state, state_nxt;
    logic [FLUSH_CNT_W-1:0] fcnt, fcnt_nxt;
    logic [CNT_W-1:0]       stall_cnt, flush_cnt;
    logic                   load_use, flush_inc;
    logic                   pc_write, if_id_write, id_ex_write, ex_mem_write;
    logic                   if_id_flush, id_ex_bubble;

    hazard_detect u_detect (
        .mem_read (bus.id_ex_MemRead_i),
        .wr       (bus.id_ex_wr_i),
        .rs1      (bus.if_id_rs1_i),
        .rs2      (bus.if_id_rs2_i),
        .uses_rs2 (bus.if_id_uses_rs2_i),
        .load_use (load_use)
    );

    // Output decode and next-state selection for the current cycle.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_write  = 1'b1;
        ex_mem_write = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        flush_inc    = 1'b0;
        state_nxt    = state;
        fcnt_nxt     = fcnt;
        if (!rst_n) begin
            {pc_write, if_id_write, id_ex_write, ex_mem_write} = 4'b0000;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            state_nxt    = ST_RUN;
            fcnt_nxt     = '0;
        end else if (bus.dmem_busy_i) begin
            {pc_write, if_id_write, id_ex_write, ex_mem_write} = 4'b0000;
            state_nxt = ST_MEM_WAIT;
            fcnt_nxt  = '0;
        end else begin
            case (state)
                ST_FLUSH: begin
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                    if (bus.branch_taken_i) begin
                        flush_inc = 1'b1;
                        fcnt_nxt  = FLUSH_LOAD;
                    end else if (fcnt <= FLUSH_CNT_W'(1)) begin
                        state_nxt = ST_RUN;
                        fcnt_nxt  = '0;
                    end else begin
                        fcnt_nxt = fcnt - FLUSH_CNT_W'(1);
                    end
                end
                ST_LOAD_STALL: state_nxt = ST_RUN;
                // RUN, and MEM_WAIT once memory is free, follow the run rules.
                default: begin
                    state_nxt = ST_RUN;
                    if (bus.branch_taken_i) begin
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                        flush_inc    = 1'b1;
                        if (MULTI_FLUSH) begin
                            state_nxt = ST_FLUSH;
                            fcnt_nxt  = FLUSH_LOAD;
                        end
                    end else if (load_use) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_bubble = 1'b1;
                        state_nxt    = ST_LOAD_STALL;
                    end
                end
            endcase
        end
    end

    // State, flush down-counter and saturating performance counters.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments; reset is sampled synchronously here.
        if (!rst_n) begin
            state     <= ST_RUN;
            fcnt      <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state <= state_nxt;
            fcnt  <= fcnt_nxt;
            if (!pc_write && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_inc && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    assign bus.pc_write_o     = pc_write;
    assign bus.if_id_write_o  = if_id_write;
    assign bus.id_ex_write_o  = id_ex_write;
    assign bus.ex_mem_write_o = ex_mem_write;
    assign bus.if_id_flush_o  = if_id_flush;
    assign bus.id_ex_bubble_o = id_ex_bubble;
    assign bus.state_o        = state;
    assign bus.stall_cnt_o    = stall_cnt;
    assign bus.flush_cnt_o    = flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (FLUSH_CYCLES=3/CNT_W=4 and the
// defaults) share one stimulus stream; a cycle-level reference model
// pushes expected outputs into a queue that a negedge monitor drains.
module tb_hazard_ctrl;

    typedef struct packed {
        logic        pc, ifid, idex, exmem, flush, bubble;
        logic [1:0]  state;
        logic [15:0] sc, fcnt;
    } obs_t;

    typedef struct packed {
        obs_t a;
        obs_t b;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mr = 1'b0, u2 = 1'b0, br = 1'b0, busy = 1'b0;
    logic [4:0] wr = '0, rs1 = '0, rs2 = '0;

    int   n_checks = 0;
    int   n_err    = 0;
    exp_t q[$];

    // Reference model state per instance: 0 = FLUSH_CYCLES 3 / 4-bit, 1 = defaults.
    int m_wait[2], m_pend[2], m_owed[2], m_sc[2], m_fc[2];

    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(4))  bus_a ();
    hazard_ctrl_if #(.CNT_W(16)) bus_b ();

    assign bus_a.id_ex_MemRead_i  = mr;
    assign bus_a.id_ex_wr_i       = wr;
    assign bus_a.if_id_rs1_i      = rs1;
    assign bus_a.if_id_rs2_i      = rs2;
    assign bus_a.if_id_uses_rs2_i = u2;
    assign bus_a.branch_taken_i   = br;
    assign bus_a.dmem_busy_i      = busy;
    assign bus_b.id_ex_MemRead_i  = mr;
    assign bus_b.id_ex_wr_i       = wr;
    assign bus_b.if_id_rs1_i      = rs1;
    assign bus_b.if_id_rs2_i      = rs2;
    assign bus_b.if_id_uses_rs2_i = u2;
    assign bus_b.branch_taken_i   = br;
    assign bus_b.dmem_busy_i      = busy;

    hazard_ctrl #(.FLUSH_CYCLES(3), .CNT_W(4)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.slave)
    );

    hazard_ctrl dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.slave)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat_inc(input int v, input int w);
        int maxv = (1 << w) - 1;
        return (v < maxv) ? v + 1 : maxv;
    endfunction

    // One cycle of the pipeline-control rules for instance k.
    function automatic obs_t model(input int k, input int fc, input int w);
        obs_t o;
        bit   lu;
        o.state = m_wait[k] != 0 ? 2'd3 : (m_owed[k] > 0 ? 2'd2 : (m_pend[k] != 0 ? 2'd1 : 2'd0));
        o.sc    = 16'(m_sc[k]);
        o.fcnt  = 16'(m_fc[k]);
        lu = mr && (wr != 0) && ((wr == rs1) || (u2 && (wr == rs2)));
        {o.pc, o.ifid, o.idex, o.exmem} = 4'b1111;
        o.flush  = 1'b0;
        o.bubble = 1'b0;
        if (!rst_n) begin
            {o.pc, o.ifid, o.idex, o.exmem} = 4'b0000;
            o.flush  = 1'b1;
            o.bubble = 1'b1;
            m_wait[k] = 0; m_pend[k] = 0; m_owed[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
        end else if (busy) begin
            {o.pc, o.ifid, o.idex, o.exmem} = 4'b0000;
            m_wait[k] = 1; m_pend[k] = 0; m_owed[k] = 0;
            m_sc[k] = sat_inc(m_sc[k], w);
        end else if (m_owed[k] > 0) begin
            o.flush  = 1'b1;
            o.bubble = 1'b1;
            if (br) begin
                m_owed[k] = fc - 1;
                m_fc[k]   = sat_inc(m_fc[k], w);
            end else begin
                m_owed[k]--;
            end
        end else if (m_pend[k] != 0) begin
            m_pend[k] = 0;
        end else begin
            m_wait[k] = 0;
            if (br) begin
                o.flush   = 1'b1;
                o.bubble  = 1'b1;
                m_owed[k] = fc - 1;
                m_fc[k]   = sat_inc(m_fc[k], w);
            end else if (lu) begin
                o.pc      = 1'b0;
                o.ifid    = 1'b0;
                o.bubble  = 1'b1;
                m_pend[k] = 1;
                m_sc[k]   = sat_inc(m_sc[k], w);
            end
        end
        return o;
    endfunction

    task automatic step(input logic r, input logic m, input logic [4:0] w, input logic [4:0] a,
                        input logic [4:0] b, input logic u, input logic bri, input logic bz);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = r; mr = m; wr = w; rs1 = a; rs2 = b; u2 = u; br = bri; busy = bz;
        e.a = model(0, 3, 4);
        e.b = model(1, 1, 16);
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    // Monitor: compare both instances against the queued expectation.
    always @(negedge clk) begin
        exp_t e;
        obs_t ga, gb;
        if (q.size() > 0) begin
            e  = q.pop_front();
            ga = '{bus_a.pc_write_o, bus_a.if_id_write_o, bus_a.id_ex_write_o, bus_a.ex_mem_write_o,
                   bus_a.if_id_flush_o, bus_a.id_ex_bubble_o, bus_a.state_o,
                   16'(bus_a.stall_cnt_o), 16'(bus_a.flush_cnt_o)};
            gb = '{bus_b.pc_write_o, bus_b.if_id_write_o, bus_b.id_ex_write_o, bus_b.ex_mem_write_o,
                   bus_b.if_id_flush_o, bus_b.id_ex_bubble_o, bus_b.state_o,
                   bus_b.stall_cnt_o, bus_b.flush_cnt_o};
            check("dut_a_cycle", 64'(ga), 64'(e.a));
            check("dut_b_cycle", 64'(gb), 64'(e.b));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_state", 64'(bus_a.state_o), 64'd0);
        check("reset_stall_cnt", 64'(bus_a.stall_cnt_o), 64'd0);

        // Load-use on rs1: one stall cycle, then LOAD_STALL, then RUN.
        idle(1);
        step(1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
        at_neg();
        check("lu_pc_write", 64'(bus_a.pc_write_o), 64'd0);
        check("lu_bubble", 64'(bus_a.id_ex_bubble_o), 64'd1);
        idle(1);
        at_neg();
        check("lu_state_stall", 64'(bus_a.state_o), 64'd1);
        check("lu_resume", 64'(bus_a.pc_write_o), 64'd1);
        idle(1);
        at_neg();
        check("lu_state_run", 64'(bus_a.state_o), 64'd0);
        check("lu_stall_cnt", 64'(bus_a.stall_cnt_o), 64'd1);

        // x0 destination and unused rs2 never stall.
        step(1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        at_neg();
        check("x0_no_stall", 64'(bus_a.pc_write_o), 64'd1);
        step(1'b1, 1'b1, 5'd7, 5'd1, 5'd7, 1'b0, 1'b0, 1'b0);
        at_neg();
        check("rs2_unused_no_stall", 64'(bus_a.pc_write_o), 64'd1);

        // Branch with FLUSH_CYCLES=3: three flush cycles, states 0,2,2 then 0.
        step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        at_neg();
        check("br_flush_c0", 64'({bus_a.if_id_flush_o, bus_a.id_ex_bubble_o, bus_a.state_o}), 64'b11_00);
        idle(1);
        at_neg();
        check("br_flush_c1", 64'({bus_a.if_id_flush_o, bus_a.id_ex_bubble_o, bus_a.state_o}), 64'b11_10);
        idle(1);
        at_neg();
        check("br_flush_c2", 64'({bus_a.if_id_flush_o, bus_a.id_ex_bubble_o, bus_a.state_o}), 64'b11_10);
        idle(1);
        at_neg();
        check("br_flush_done", 64'({bus_a.if_id_flush_o, bus_a.state_o}), 64'b0_00);
        check("br_flush_cnt", 64'(bus_a.flush_cnt_o), 64'd1);

        // Memory busy for 4 cycles overrides branch and load-use.
        step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b1, 1'b1);
            at_neg();
            check("busy_frozen",
                  64'({bus_a.pc_write_o, bus_a.if_id_write_o, bus_a.id_ex_write_o,
                       bus_a.ex_mem_write_o, bus_a.if_id_flush_o, bus_a.id_ex_bubble_o}), 64'd0);
        end
        idle(1);
        at_neg();
        check("busy_state_wait", 64'(bus_a.state_o), 64'd3);
        check("busy_stall_cnt", 64'(bus_a.stall_cnt_o), 64'd4);
        check("busy_no_flush_cnt", 64'(bus_a.flush_cnt_o), 64'd0);

        // Reset during the second FLUSH cycle aborts the flush.
        step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        idle(1);
        step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        idle(1);
        at_neg();
        check("rst_abort_state", 64'(bus_a.state_o), 64'd0);
        check("rst_abort_flush", 64'(bus_a.if_id_flush_o), 64'd0);
        check("rst_abort_cnts", 64'({bus_a.stall_cnt_o, bus_a.flush_cnt_o}), 64'd0);

        // 20 stalled cycles saturate the 4-bit counter at 15.
        step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        idle(1);
        at_neg();
        check("sat_stall_cnt_4b", 64'(bus_a.stall_cnt_o), 64'd15);
        check("sat_stall_cnt_16b", 64'(bus_b.stall_cnt_o), 64'd20);

        // Randomized traffic with narrow register ranges to force collisions.
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 49) != 0), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 99) < 15),
                 1'($urandom_range(0, 99) < 12));
        end
        idle(1);
        at_neg();
        check("queue_drained", 64'(q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 1, number of consecutive cycles IF/ID and ID/EX are flushed per taken branch (legal range 1..7).
REQ-002 SHALL have parameter CNT_W, default 16, width of the performance counters.
REQ-003 SHALL use one clock; reset is synchronous and active-low: clk input 1, rising-edge clock.
REQ-004 SHALL have rst_n input 1, synchronous active-low reset.
REQ-005 SHALL have id_ex_MemRead_i input 1, load instruction currently in EX.
REQ-006 SHALL have id_ex_wr_i input 5, destination register of the instruction in EX.
REQ-007 SHALL have if_id_rs1_i and if_id_rs2_i inputs, 5 each, source registers of the instruction in ID.
REQ-008 SHALL have if_id_uses_rs2_i input 1, high when the ID instruction reads rs2.
REQ-009 SHALL have branch_taken_i input 1, branch resolved taken in EX.
REQ-010 SHALL have dmem_busy_i input 1, data memory cannot complete this cycle.
REQ-011 SHALL have pc_write_o, if_id_write_o, id_ex_write_o and ex_mem_write_o outputs, 1 each, per-stage update enables.
REQ-012 SHALL have if_id_flush_o output 1 (zero IF/ID) and id_ex_bubble_o output 1 (load all-zero control into ID/EX).
REQ-013 SHALL have state_o output 2, current FSM state.
REQ-014 SHALL have stall_cnt_o and flush_cnt_o outputs, CNT_W each, performance counters.

Function
REQ-015 SHALL implement the states RUN=0, LOAD_STALL=1, FLUSH=2 and MEM_WAIT=3.
REQ-016 SHALL define load_use = id_ex_MemRead_i & (id_ex_wr_i!=0) & (id_ex_wr_i==if_id_rs1_i | (if_id_uses_rs2_i & id_ex_wr_i==if_id_rs2_i)).
REQ-017 SHALL resolve conditions with priority dmem_busy_i > branch_taken_i > load_use, evaluated combinationally in the same cycle (Mealy outputs, zero latency).
REQ-018 SHALL, whenever dmem_busy_i=1 in any state, drive all four write enables to 0 and bubble/flush to 0, go to MEM_WAIT, and ignore branch_taken_i and load_use.
REQ-019 SHALL, in MEM_WAIT with dmem_busy_i=0, return to RUN and apply the RUN rules in that same cycle.
REQ-020 SHALL, in RUN with branch_taken_i=1, drive if_id_flush_o=1, id_ex_bubble_o=1 and all write enables 1, increment flush_cnt_o, and go to FLUSH if FLUSH_CYCLES>1, otherwise stay in RUN.
REQ-021 SHALL, in FLUSH, keep if_id_flush_o=1 and id_ex_bubble_o=1 for FLUSH_CYCLES-1 cycles total using an internal 3-bit down-counter, then return to RUN.
REQ-022 SHALL, for a branch_taken_i pulse during FLUSH, restart the down-counter and increment flush_cnt_o.
REQ-023 SHALL, in RUN with load_use=1, drive pc_write_o=0, if_id_write_o=0 and id_ex_bubble_o=1, and go to LOAD_STALL.
REQ-024 SHALL, in LOAD_STALL, drive normal enables with no bubble and go to RUN; the stall is exactly one cycle per load-use pair.
REQ-025 SHALL otherwise, in RUN, drive all write enables 1 and bubble/flush 0.
REQ-026 SHALL increment stall_cnt_o on every cycle with pc_write_o=0; both counters saturate at all-ones and never wrap.

Reset
REQ-027 SHALL, while rst_n=0 at a clock edge, set state RUN, the flush down-counter to 0 and both counters to 0.
REQ-028 SHALL, while rst_n=0, combinationally drive all write enables 0, if_id_flush_o=1 and id_ex_bubble_o=1.
REQ-029 SHALL let reset asserted mid-FLUSH or mid-MEM_WAIT abort the sequence, with no residual flush after release.

Structure
REQ-030 SHALL place the state encoding, REG_ADDR_W=5 and the counter default width in a shared package, pipe_ctrl_pkg.
REQ-031 SHALL place the load_use comparison in a combinational sub-module, hazard_detect.

Verification
REQ-032 SHALL test load-use: MemRead=1, wr=5, rs1=5 -> one cycle with pc_write=0 and bubble=1, then RUN; stall_cnt=1.
REQ-033 SHALL test the x0 and rs2 cases: wr=0, rs1=0 -> no stall; wr=7, rs2=7, uses_rs2=0 -> no stall.
REQ-034 SHALL test branch with FLUSH_CYCLES=3 -> flush/bubble high for 3 cycles, flush_cnt=1, state 0->2->2->0.
REQ-035 SHALL test dmem_busy high 4 cycles together with branch_taken and load_use -> 4 frozen cycles, no flush, stall_cnt=4.
REQ-036 SHALL test reset asserted in FLUSH cycle 2 -> RUN, counters 0, no flush on the cycle after release.
REQ-037 SHALL test saturation with CNT_W=4 and 20 stall cycles -> stall_cnt=15.
